// File: rtl/uart16550_echo_master.sv
// -----------------------------------------------------------------------------
// uart16550_echo_master
//
// AXI4-Lite initiator that brings up a UART16550 slave and then runs a
// hardware echo loop: wait for receive data, read it, wait for the transmit
// holding register to empty, and write the same byte back.
//
// Ports:
//   s_axi_aclk / s_axi_areset   clock, asynchronous active-high reset
//   enable                      run request; sampled only between transactions
//   m_axi_aw* / m_axi_w* / m_axi_b*   write channels (one byte in wdata[7:0])
//   m_axi_ar* / m_axi_r*              read channels (rdata[7:0] used)
//   init_done                   sticky: the 16550 init writes have completed
//   rx_byte / rx_strobe         last byte read from RBR, one-cycle update pulse
//   echo_count                  bytes written back to THR (wraps)
//   bus_error                   sticky: a non-OKAY BRESP or RRESP was seen
// -----------------------------------------------------------------------------
module uart16550_echo_master #(
    parameter logic [12:0] REG_BASE = 13'h1000,
    parameter logic [15:0] DIVISOR  = 16'd54,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter logic [7:0]  POLL_GAP = 8'd16
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_areset,
    input  logic        enable,
    output logic [12:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [12:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        init_done,
    output logic [7:0]  rx_byte,
    output logic        rx_strobe,
    output logic [15:0] echo_count,
    output logic        bus_error
);

    // Register offsets (registers are 32-bit aligned).
    localparam logic [12:0] OFF_RBR = 13'h000;   // RBR / THR / DLL
    localparam logic [12:0] OFF_IER = 13'h004;   // IER / DLM
    localparam logic [12:0] OFF_FCR = 13'h008;
    localparam logic [12:0] OFF_LCR = 13'h00C;
    localparam logic [12:0] OFF_LSR = 13'h014;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_POLL_RX,
        ST_RD_RBR,
        ST_POLL_TX,
        ST_WR_THR
    } state_t;

    typedef enum logic [2:0] {
        BUS_IDLE,
        BUS_WADDR,   // AW and W issued, waiting for both handshakes
        BUS_WRESP,   // bready high, waiting for bvalid
        BUS_RADDR,   // arvalid high, waiting for arready
        BUS_RDATA    // rready high, waiting for rvalid
    } bus_t;

    state_t      state_reg;
    bus_t        bus_reg;
    logic [2:0]  init_idx_reg;
    logic [7:0]  gap_reg;

    logic        bus_idle;
    logic        wr_fire;
    logic        rd_fire;
    logic [12:0] init_off;
    logic [7:0]  init_data;
    logic        unused_rdata_hi;

    assign m_axi_wstrb     = 4'b0001;
    assign unused_rdata_hi = ^m_axi_rdata[31:8];

    // bready / rready are high throughout their respective wait phases, so
    // the completing handshake is just the slave's valid in that phase.
    assign bus_idle = (bus_reg == BUS_IDLE);
    assign wr_fire  = (bus_reg == BUS_WRESP) && m_axi_bvalid;
    assign rd_fire  = (bus_reg == BUS_RDATA) && m_axi_rvalid;

    // Init write table: set DLAB, program the divisor, select the line
    // format (clearing DLAB), enable and flush FIFOs, mask interrupts.
    always_comb begin
        init_off  = OFF_LCR;
        init_data = 8'h80;
        case (init_idx_reg)
            3'd0: begin init_off = OFF_LCR; init_data = 8'h80;          end
            3'd1: begin init_off = OFF_RBR; init_data = DIVISOR[7:0];   end
            3'd2: begin init_off = OFF_IER; init_data = DIVISOR[15:8];  end
            3'd3: begin init_off = OFF_LCR; init_data = LCR_VAL;        end
            3'd4: begin init_off = OFF_FCR; init_data = 8'h07;          end
            3'd5: begin init_off = OFF_IER; init_data = 8'h00;          end
            default: ;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_reg     <= ST_IDLE;
            bus_reg       <= BUS_IDLE;
            init_idx_reg  <= 3'd0;
            gap_reg       <= 8'd0;
            m_axi_awaddr  <= 13'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= 32'd0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= 13'd0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            init_done     <= 1'b0;
            rx_byte       <= 8'd0;
            rx_strobe     <= 1'b0;
            echo_count    <= 16'd0;
            bus_error     <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;

            // ---------------- bus channel engine ----------------
            case (bus_reg)
                BUS_WADDR: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    // Each channel is done if it already handshook or does now.
                    if ((!m_axi_awvalid || m_axi_awready) &&
                        (!m_axi_wvalid  || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        bus_reg      <= BUS_WRESP;
                    end
                end
                BUS_WRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        bus_reg      <= BUS_IDLE;
                        if (m_axi_bresp != 2'b00) bus_error <= 1'b1;
                    end
                end
                BUS_RADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        bus_reg       <= BUS_RDATA;
                    end
                end
                BUS_RDATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        bus_reg      <= BUS_IDLE;
                        if (m_axi_rresp != 2'b00) bus_error <= 1'b1;
                    end
                end
                default: ;
            endcase

            // ---------------- sequencer ----------------
            // New transactions are only launched while the bus engine is idle,
            // so the launch assignments never collide with the engine above.
            case (state_reg)
                ST_IDLE: begin
                    if (enable) begin
                        init_idx_reg <= 3'd0;
                        gap_reg      <= 8'd0;
                        state_reg    <= init_done ? ST_POLL_RX : ST_INIT;
                    end
                end

                ST_INIT: begin
                    if (bus_idle) begin
                        if (!enable) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            m_axi_awaddr  <= REG_BASE + init_off;
                            m_axi_wdata   <= {24'd0, init_data};
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            bus_reg       <= BUS_WADDR;
                        end
                    end
                    if (wr_fire) begin
                        if (init_idx_reg == 3'd5) begin
                            init_done <= 1'b1;
                            state_reg <= ST_POLL_RX;
                        end else begin
                            init_idx_reg <= init_idx_reg + 3'd1;
                        end
                    end
                end

                ST_POLL_RX: begin
                    if (gap_reg != 8'd0) begin
                        gap_reg <= gap_reg - 8'd1;
                    end else if (bus_idle) begin
                        // Only place, besides INIT, where a stop request is honoured:
                        // no byte is held here.
                        if (!enable) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            m_axi_araddr  <= REG_BASE + OFF_LSR;
                            m_axi_arvalid <= 1'b1;
                            bus_reg       <= BUS_RADDR;
                        end
                    end
                    if (rd_fire) begin
                        if (m_axi_rdata[0]) state_reg <= ST_RD_RBR;
                        else                gap_reg   <= POLL_GAP;
                    end
                end

                ST_RD_RBR: begin
                    if (bus_idle) begin
                        m_axi_araddr  <= REG_BASE + OFF_RBR;
                        m_axi_arvalid <= 1'b1;
                        bus_reg       <= BUS_RADDR;
                    end
                    if (rd_fire) begin
                        rx_byte   <= m_axi_rdata[7:0];
                        rx_strobe <= 1'b1;
                        gap_reg   <= 8'd0;
                        state_reg <= ST_POLL_TX;
                    end
                end

                ST_POLL_TX: begin
                    if (gap_reg != 8'd0) begin
                        gap_reg <= gap_reg - 8'd1;
                    end else if (bus_idle) begin
                        m_axi_araddr  <= REG_BASE + OFF_LSR;
                        m_axi_arvalid <= 1'b1;
                        bus_reg       <= BUS_RADDR;
                    end
                    if (rd_fire) begin
                        if (m_axi_rdata[5]) state_reg <= ST_WR_THR;
                        else                gap_reg   <= POLL_GAP;
                    end
                end

                ST_WR_THR: begin
                    if (bus_idle) begin
                        m_axi_awaddr  <= REG_BASE + OFF_RBR;
                        m_axi_wdata   <= {24'd0, rx_byte};
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        bus_reg       <= BUS_WADDR;
                    end
                    if (wr_fire) begin
                        echo_count <= echo_count + 16'd1;
                        state_reg  <= ST_POLL_RX;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart16550_echo_master.sv
// -----------------------------------------------------------------------------
// tb_uart16550_echo_master
//
// Drives uart16550_echo_master against a behavioural UART16550 slave: a byte
// FIFO for receive data, a per-byte count of "transmitter busy" LSR replies,
// randomized channel ready delays and an injectable read error. Every write
// the slave accepts is logged; the bench compares the logged traffic, the
// status outputs and a protocol/poll-spacing monitor against expectations
// derived from the UART init recipe and echo behaviour.
// -----------------------------------------------------------------------------
module tb_uart16550_echo_master;

    localparam logic [12:0] BASE = 13'h1000;
    localparam int          GAP  = 16;
    localparam logic [12:0] EXP_A [6] = '{13'h100C, 13'h1000, 13'h1004,
                                          13'h100C, 13'h1008, 13'h1004};
    localparam logic [7:0]  EXP_D [6] = '{8'h80, 8'h36, 8'h00, 8'h03, 8'h07, 8'h00};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [12:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [12:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic        init_done;
    logic [7:0]  rx_byte;
    logic        rx_strobe;
    logic [15:0] echo_count;
    logic        bus_error;

    always #5 clk = ~clk;

    uart16550_echo_master dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .enable        (enable),
        .m_axi_awaddr  (awaddr),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .init_done     (init_done),
        .rx_byte       (rx_byte),
        .rx_strobe     (rx_strobe),
        .echo_count    (echo_count),
        .bus_error     (bus_error)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- slave model state ----------------
    // Written by the stimulus process only:
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    int          busy_cfg = 0;
    int          err_req = 0;
    int          rx_wr = 0;
    logic [7:0]  rx_mem [64];
    // Written by the slave process only:
    int          aw_cnt, w_cnt, ar_cnt;
    logic        aw_got, w_got;
    logic [12:0] aw_l;
    logic [31:0] w_l;
    int          rx_rd = 0;
    logic        tx_phase;
    int          tx_busy, tx_polls;
    int          err_done = 0;
    logic        lsr_busy, rd_is_lsr;
    logic [12:0] wa_q [$];
    logic [31:0] wd_q [$];

    function automatic logic [31:0] lsr_word(input logic dr, input logic thre, input logic [3:0] noise);
        return {24'h0, 1'b0, thre, thre, noise, dr};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            arready <= 1'b0; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'd0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            tx_phase <= 1'b0; tx_busy <= 0; rx_rd <= rx_wr;
            lsr_busy <= 1'b0; rd_is_lsr <= 1'b0;
        end else begin
            awready <= 1'b0;
            wready  <= 1'b0;
            arready <= 1'b0;
            if (awvalid && !awready && !aw_got) begin
                if (aw_cnt >= aw_dly) awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (awvalid && awready) begin aw_got <= 1'b1; aw_l <= awaddr; aw_cnt <= 0; end
            if (wvalid && !wready && !w_got) begin
                if (w_cnt >= w_dly) wready <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end
            if (wvalid && wready) begin w_got <= 1'b1; w_l <= wdata; w_cnt <= 0; end
            if (aw_got && w_got && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= 2'b00;
                wa_q.push_back(aw_l);
                wd_q.push_back(w_l);
                if (aw_l == BASE) tx_phase <= 1'b0;
            end
            if (bvalid && bready) begin bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; end

            if (arvalid && !arready && !rvalid) begin
                if (ar_cnt >= ar_dly) arready <= 1'b1;
                else ar_cnt <= ar_cnt + 1;
            end
            if (arvalid && arready) begin
                ar_cnt <= 0;
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                rd_is_lsr <= 1'b0;
                if (araddr == BASE + 13'd20) begin
                    rd_is_lsr <= 1'b1;
                    rdata <= lsr_word(rx_rd != rx_wr,
                                      tx_phase ? (tx_busy == 0) : 1'($urandom_range(0, 1)),
                                      4'($urandom));
                    lsr_busy <= tx_phase ? (tx_busy != 0) : (rx_rd == rx_wr);
                    if (tx_phase) begin
                        tx_polls <= tx_polls + 1;
                        if (tx_busy > 0) tx_busy <= tx_busy - 1;
                    end
                    if (err_req != err_done) begin
                        rresp    <= 2'b10;
                        err_done <= err_done + 1;
                    end
                end else if (araddr == BASE) begin
                    rdata    <= (rx_rd != rx_wr) ? {24'h0, rx_mem[rx_rd % 64]} : 32'h0;
                    if (rx_rd != rx_wr) rx_rd <= rx_rd + 1;
                    tx_phase <= 1'b1;
                    tx_busy  <= busy_cfg;
                    tx_polls <= 0;
                end else begin
                    rdata <= 32'h0;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- protocol / spacing monitor ----------------
    int          viol = 0, viol_gap = 0, gap_checked = 0;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_strobe;
    logic [12:0] p_awa, p_ara;
    logic [31:0] p_wd;
    logic        gap_arm;
    int          gap_cnt;
    logic [7:0]  sb_q [$];

    always @(negedge clk) begin
        if (rst) begin
            p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0;
            p_arv <= 1'b0; p_arr <= 1'b0; p_strobe <= 1'b0; gap_arm <= 1'b0;
        end else begin
            if (wvalid && (wstrb != 4'b0001 || wdata[31:8] != 24'h0)) viol <= viol + 1;
            if (p_awv && !p_awr && (!awvalid || awaddr != p_awa))   viol <= viol + 1;
            if (p_wv && !p_wr && (!wvalid || wdata != p_wd))        viol <= viol + 1;
            if (p_arv && !p_arr && (!arvalid || araddr != p_ara))   viol <= viol + 1;
            if (bready && (awvalid || wvalid))                      viol <= viol + 1;
            if ((arvalid || rready) && (awvalid || wvalid || bready)) viol <= viol + 1;
            if (rx_strobe && p_strobe)                              viol <= viol + 1;
            if (rx_strobe) sb_q.push_back(rx_byte);

            if (rvalid && rready) begin
                gap_arm <= lsr_busy && rd_is_lsr;
                gap_cnt <= 0;
            end else if (gap_arm) begin
                if (arvalid) begin
                    if (gap_cnt < GAP) viol_gap <= viol_gap + 1;
                    gap_checked <= gap_checked + 1;
                    gap_arm <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + 1;
                end
            end

            p_awv <= awvalid; p_awr <= awready; p_awa <= awaddr;
            p_wv  <= wvalid;  p_wr  <= wready;  p_wd  <= wdata;
            p_arv <= arvalid; p_arr <= arready; p_ara <= araddr;
            p_strobe <= rx_strobe;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_init(input string tag);
        int base = wa_q.size();
        int c = 0;
        while (!init_done && c < 2000) begin @(negedge clk); c++; end
        check({tag, "_timeout"}, 32'(c < 2000), 1);
        check({tag, "_nwrites"}, wa_q.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < wa_q.size()) begin
                check($sformatf("%s_addr%0d", tag, i), {19'h0, wa_q[base + i]}, {19'h0, EXP_A[i]});
                check($sformatf("%s_data%0d", tag, i), wd_q[base + i], {24'h0, EXP_D[i]});
            end
        end
        $display("init %s: %0d writes, init_done=%0b", tag, wa_q.size() - base, init_done);
    endtask

    task automatic do_echo(input logic [7:0] b, input int busy);
        int          sb0 = sb_q.size();
        int          wa0 = wa_q.size();
        logic [15:0] ec0 = echo_count;
        int          c = 0;
        busy_cfg = busy;
        rx_mem[rx_wr % 64] = b;
        rx_wr++;
        while (echo_count == ec0 && c < 4000) begin @(negedge clk); c++; end
        check("echo_timeout", 32'(c < 4000), 1);
        check("echo_count", {16'h0, echo_count}, {16'h0, ec0 + 16'd1});
        check("strobe_count", sb_q.size() - sb0, 1);
        check("rx_byte", (sb_q.size() > sb0) ? {24'h0, sb_q[sb0]} : 32'hFFFF_FFFF, {24'h0, b});
        check("thr_writes", wa_q.size() - wa0, 1);
        if (wa_q.size() > wa0) begin
            check("thr_addr", {19'h0, wa_q[wa0]}, {19'h0, BASE});
            check("thr_data", wd_q[wa0], {24'h0, b});
        end
        check("tx_polls", tx_polls, busy + 1);
        $display("echo byte=%02h busy_polls=%0d tx_polls=%0d count=%0d", b, busy, tx_polls, echo_count);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c;
        int traffic;
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valids", {27'h0, awvalid, wvalid, arvalid, bready, rready}, 0);
        check("rst_addr", {6'h0, awaddr, araddr}, 0);
        check("rst_wdata", wdata, 0);
        check("rst_status", {29'h0, init_done, rx_strobe, bus_error}, 0);
        check("rst_rx_byte", {24'h0, rx_byte}, 0);
        check("rst_echo_count", {16'h0, echo_count}, 0);

        rst = 1'b0;
        enable = 1'b1;
        run_init("init1");

        do_echo(8'h5A, 0);
        aw_dly = 5; w_dly = 2;
        do_echo(8'($urandom), 3);
        aw_dly = 0; w_dly = 0;
        check("bus_error_clear", {31'h0, bus_error}, 0);

        for (int k = 0; k < 8; k++) begin
            aw_dly = $urandom_range(0, 5);
            w_dly  = $urandom_range(0, 5);
            ar_dly = $urandom_range(0, 5);
            if (k == 3) err_req++;
            do_echo(8'($urandom), $urandom_range(0, 3));
            if (k == 3) check("bus_error_set", {31'h0, bus_error}, 1);
        end
        check("echo_total", {16'h0, echo_count}, 10);
        check("bus_error_sticky", {31'h0, bus_error}, 1);

        // Stop request: after the current transaction the bus must go quiet.
        enable = 1'b0;
        repeat (60) @(negedge clk);
        traffic = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (awvalid || wvalid || arvalid) traffic++;
        end
        check("idle_traffic", traffic, 0);
        check("idle_init_done", {31'h0, init_done}, 1);
        enable = 1'b1;
        ar_dly = 0;
        do_echo(8'($urandom), 1);

        // Reset while a read address is pending.
        ar_dly = 4;
        c = 0;
        while (!arvalid && c < 500) begin @(negedge clk); c++; end
        check("mid_wait_arvalid", {31'h0, arvalid}, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_arvalid", {31'h0, arvalid}, 0);
        check("mid_rst_status", {29'h0, init_done, bus_error, rready}, 0);
        check("mid_rst_echo_count", {16'h0, echo_count}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ar_dly = 0;
        run_init("init2");
        do_echo(8'($urandom), 0);

        check("protocol_viol", viol, 0);
        check("poll_gap_viol", viol_gap, 0);
        check("poll_gap_measured", 32'(gap_checked > 0), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
